// File: rtl/alu_seq.sv
// Registered ALU with AVR-style SREG flags, carry-chained ADC/SBC and a
// shift-add unsigned multiplier; one operation per start/done handshake.
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            opsel,
    input  logic [DATA_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] rr,
    input  logic [7:0]            flags_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] out_hi,
    output logic [7:0]            flags_out,
    output logic                  illegal
);
    localparam int W  = DATA_WIDTH;
    localparam int M  = W - 1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [7:0] OP_NONE = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADC  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_SBC  = 8'h04;
    localparam logic [7:0] OP_AND  = 8'h05;
    localparam logic [7:0] OP_OR   = 8'h06;
    localparam logic [7:0] OP_XOR  = 8'h07;
    localparam logic [7:0] OP_NEG  = 8'h08;
    localparam logic [7:0] OP_MUL  = 8'h09;

    localparam int FC = 0;
    localparam int FZ = 1;
    localparam int FN = 2;
    localparam int FV = 3;
    localparam int FS = 4;
    localparam int FH = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [7:0]     op_q;
    logic [W-1:0]   rd_q, rr_q;
    logic [7:0]     fl_q;
    logic [2*W-1:0] prod, mul_nx;
    logic [W:0]     mul_sum;
    logic [CW-1:0]  cnt;

    logic           carry_in;
    logic [W:0]     rd_x, rr_x, add_ext, sub_ext;
    logic [W-1:0]   add_res, sub_res;
    logic           add_v, sub_v, add_h, sub_h;

    logic [W-1:0]   res, res_hi;
    logic [7:0]     fl_nx;
    logic           ill;

    // Handshake: start is sampled only in IDLE; busy covers EXEC and MUL;
    // done pulses for one cycle with busy already low, so a start in that
    // same cycle is accepted and operations can run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = (opsel == OP_MUL && MUL_ENABLE) ? S_MUL : S_EXEC;
            S_MUL:  if (cnt == CNT_LAST) state_nx = S_EXEC;
            S_EXEC: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // One shift-add step: add rd into the upper half when the current
    // multiplier LSB is set, then shift the whole product right.
    assign mul_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, rd_q} : {(W+1){1'b0}});
    assign mul_nx  = {mul_sum, prod[W-1:1]};

    assign carry_in = fl_q[FC] & ((op_q == OP_ADC) | (op_q == OP_SBC));
    assign rd_x     = {1'b0, rd_q};
    assign rr_x     = {1'b0, rr_q};
    assign add_ext  = rd_x + rr_x + {{W{1'b0}}, carry_in};
    assign sub_ext  = rd_x - rr_x - {{W{1'b0}}, carry_in};
    assign add_res  = add_ext[W-1:0];
    assign sub_res  = sub_ext[W-1:0];
    // Bit 4 of operand ^ operand ^ result recovers the carry/borrow out of bit 3.
    assign add_h    = rd_x[4] ^ rr_x[4] ^ add_ext[4];
    assign sub_h    = rd_x[4] ^ rr_x[4] ^ sub_ext[4];
    assign add_v    = (rd_q[M] == rr_q[M]) & (add_res[M] != rd_q[M]);
    assign sub_v    = (rd_q[M] != rr_q[M]) & (sub_res[M] == rr_q[M]);

    always_comb begin
        res    = '0;
        res_hi = '0;
        ill    = 1'b0;
        fl_nx  = fl_q;
        case (op_q)
            OP_NONE: res = rr_q;
            OP_ADD, OP_ADC: begin
                res       = add_res;
                fl_nx[FC] = add_ext[W];
                fl_nx[FH] = add_h;
                fl_nx[FV] = add_v;
            end
            OP_SUB, OP_SBC: begin
                res       = sub_res;
                fl_nx[FC] = sub_ext[W];
                fl_nx[FH] = sub_h;
                fl_nx[FV] = sub_v;
            end
            OP_AND: begin res = rd_q & rr_q; fl_nx[FV] = 1'b0; end
            OP_OR:  begin res = rd_q | rr_q; fl_nx[FV] = 1'b0; end
            OP_XOR: begin res = rd_q ^ rr_q; fl_nx[FV] = 1'b0; end
            OP_NEG: begin res = ~rd_q;       fl_nx[FV] = 1'b0; end
            OP_MUL: begin
                if (MUL_ENABLE) begin
                    {res_hi, res} = prod;
                    fl_nx[FC]     = prod[2*W-1];
                    fl_nx[FZ]     = (prod == '0);
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (op_q >= OP_ADD && op_q <= OP_NEG) begin
            fl_nx[FN] = res[M];
            fl_nx[FS] = res[M] ^ fl_nx[FV];
            // ADC/SBC keep Z only if the lower words of the chain were zero too.
            fl_nx[FZ] = (res == '0) & (((op_q != OP_ADC) && (op_q != OP_SBC)) | fl_q[FZ]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            rd_q      <= '0;
            rr_q      <= '0;
            fl_q      <= '0;
            prod      <= '0;
            cnt       <= '0;
            out       <= '0;
            out_hi    <= '0;
            flags_out <= '0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= opsel;
                        rd_q <= rd;
                        rr_q <= rr;
                        fl_q <= flags_in;
                        prod <= {{W{1'b0}}, rr};
                        cnt  <= '0;
                    end
                end
                S_MUL: begin
                    prod <= mul_nx;
                    cnt  <= cnt + CW'(1);
                end
                S_EXEC: begin
                    out       <= res;
                    out_hi    <= res_hi;
                    flags_out <= fl_nx;
                    illegal   <= ill;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: an arithmetic reference model fills the
// expected queue at start, results are popped and compared on done.
module tb_alu_seq;
    localparam int W  = 8;
    localparam int EW = 2*W + 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   opsel;
    logic [W-1:0] rd, rr;
    logic [7:0]   flags_in;
    logic         busy, done, illegal;
    logic [W-1:0] out, out_hi;
    logic [7:0]   flags_out;

    int tests_run = 0;
    int fails     = 0;

    logic [EW-1:0] exp_q[$];

    alu_seq #(.DATA_WIDTH(W), .MUL_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opsel(opsel), .rd(rd), .rr(rr),
        .flags_in(flags_in), .busy(busy), .done(done), .out(out), .out_hi(out_hi),
        .flags_out(flags_out), .illegal(illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: result packed as {out_hi, out, flags, illegal}
    function automatic logic [EW-1:0] model(input logic [7:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [7:0] f);
        int ai, bi, sa, sb, cin, full, sr;
        logic [W-1:0] r, hi;
        logic [2*W-1:0] p;
        logic c, z, n, v, h, ill;
        logic [7:0] fo;
        ai = a; bi = b;
        sa = a[W-1] ? ai - (1 << W) : ai;
        sb = b[W-1] ? bi - (1 << W) : bi;
        r = '0; hi = '0; ill = 1'b0; fo = f; cin = 0;
        case (op)
            8'h00: r = b;
            8'h01, 8'h02: begin
                cin  = (op == 8'h02) ? int'(f[0]) : 0;
                full = ai + bi + cin;
                r    = full[W-1:0];
                c    = (full >= (1 << W));
                h    = ((ai % 16) + (bi % 16) + cin) > 15;
                sr   = sa + sb + cin;
                v    = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
                n    = r[W-1];
                z    = (r == '0) && (op == 8'h01 || f[1]);
                fo   = {f[7:6], h, n ^ v, v, n, z, c};
            end
            8'h03, 8'h04: begin
                cin = (op == 8'h04) ? int'(f[0]) : 0;
                r   = W'(ai - bi - cin);
                c   = ai < bi + cin;
                h   = (ai % 16) < (bi % 16) + cin;
                sr  = sa - sb - cin;
                v   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
                n   = r[W-1];
                z   = (r == '0) && (op == 8'h03 || f[1]);
                fo  = {f[7:6], h, n ^ v, v, n, z, c};
            end
            8'h05, 8'h06, 8'h07, 8'h08: begin
                r  = (op == 8'h05) ? (a & b) : (op == 8'h06) ? (a | b) :
                     (op == 8'h07) ? (a ^ b) : ~a;
                n  = r[W-1];
                fo = {f[7:5], n, 1'b0, n, (r == '0), f[0]};
            end
            8'h09: begin
                p       = a * b;
                {hi, r} = p;
                fo      = {f[7:2], (p == '0), p[2*W-1]};
            end
            default: ill = 1'b1;
        endcase
        return {hi, r, fo, ill};
    endfunction

    // driver: call at a negedge; start is sampled on the following posedge
    task automatic drive_op(input logic [7:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [7:0] f);
        opsel = op; rd = a; rr = b; flags_in = f; start = 1'b1;
        exp_q.push_back(model(op, a, b, f));
        @(negedge clk);
        start    = 1'b0;
        opsel    = 8'($urandom_range(0, 255));
        rd       = W'($urandom);
        rr       = W'($urandom);
        flags_in = 8'($urandom);
    endtask

    // monitor: counts negedges until done, bounded
    task automatic wait_done(output int cyc, output logic [EW-1:0] obs);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        obs = {out_hi, out, flags_out, illegal};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; opsel = '0; rd = '0; rr = '0; flags_in = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, illegal, out, out_hi, flags_out} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b ill=%b out=%h hi=%h fl=%h, expected all 0",
                     busy, done, illegal, out, out_hi, flags_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [7:0]   ops[5]  = '{8'h01, 8'h03, 8'h04, 8'h01, 8'h02};
        logic [W-1:0] as[5]   = '{8'd100, 8'h10, 8'h00, 8'hFF, 8'h00};
        logic [W-1:0] bs[5]   = '{8'd50, 8'h10, 8'h00, 8'h01, 8'h00};
        logic [7:0]   fs[5]   = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
        logic [W-1:0] eo[5]   = '{8'd150, 8'h00, 8'hFF, 8'h00, 8'h01};
        logic [7:0]   ef[5]   = '{8'h0C, 8'h02, 8'h35, 8'h23, 8'h00};
        logic [EW-1:0] obs, exp;
        logic [7:0] f;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            // the ADC step is fed the flags the DUT produced for the preceding ADD
            f = (i == 4) ? flags_out : fs[i];
            drive_op(ops[i], as[i], bs[i], f);
            wait_done(cyc, obs);
            exp = exp_q.pop_front();
            tests_run++;
            if (obs !== exp || cyc != 1) begin
                fails++;
                $display("FAIL arith_%0d: got %h after %0d cycles, expected %h after 1", i, obs, cyc, exp);
            end
            tests_run++;
            if (out !== eo[i] || flags_out !== ef[i]) begin
                fails++;
                $display("FAIL arith_const_%0d: got out=%h fl=%h, expected out=%h fl=%h",
                         i, out, flags_out, eo[i], ef[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [EW-1:0] obs, exp;
        int cyc;
        for (int op = 0; op <= 8; op++) begin
            if (op >= 1 && op <= 4) continue;
            @(negedge clk);
            drive_op(8'(op), 8'hA5, 8'h5A, 8'hE1);
            wait_done(cyc, obs);
            exp = exp_q.pop_front();
            tests_run++;
            if (obs !== exp || cyc != 1) begin
                fails++;
                $display("FAIL logic_op%0d: got %h after %0d cycles, expected %h after 1", op, obs, cyc, exp);
            end
        end
    endtask

    task automatic test_mul();
        logic [EW-1:0] obs, exp;
        logic [W-1:0] hold_out;
        int cyc, bad;
        @(negedge clk);
        drive_op(8'h09, 8'hFF, 8'hFF, 8'h00);
        cyc = 0; bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc <= 8 && busy !== 1'b1) bad++;
            if (cyc == 3) begin start = 1'b1; opsel = 8'h01; rd = 8'h01; rr = 8'h01; end
            if (cyc == 4) start = 1'b0;
        end while (!done && cyc < 40);
        obs = {out_hi, out, flags_out, illegal};
        exp = exp_q.pop_front();
        tests_run++;
        if (obs !== exp || cyc != W + 1) begin
            fails++;
            $display("FAIL mul_ff_ff: got %h after %0d cycles, expected %h after %0d", obs, cyc, exp, W + 1);
        end
        tests_run++;
        if ({out_hi, out} !== 16'hFE01 || flags_out[0] !== 1'b1 || busy !== 1'b0 || bad != 0) begin
            fails++;
            $display("FAIL mul_const: got prod=%h C=%b busy=%b busy_gaps=%0d, expected prod=fe01 C=1 busy=0 gaps=0",
                     {out_hi, out}, flags_out[0], busy, bad);
        end
        hold_out = out; bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || out !== hold_out) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mul_ignored_start_hold: got %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] obs, exp;
        int cyc;
        @(negedge clk);
        drive_op(8'h07, 8'h0F, 8'hFF, 8'h00);
        wait_done(cyc, obs);
        exp = exp_q.pop_front();
        tests_run++;
        if (obs !== exp || cyc != 1) begin
            fails++;
            $display("FAIL b2b_first: got %h after %0d cycles, expected %h after 1", obs, cyc, exp);
        end
        drive_op(8'h05, 8'hF0, 8'h3C, 8'h00);
        wait_done(cyc, obs);
        exp = exp_q.pop_front();
        tests_run++;
        if (obs !== exp || cyc != 1 || out !== 8'h30) begin
            fails++;
            $display("FAIL b2b_and: got %h out=%h after %0d cycles, expected %h out=30 after 1", obs, out, cyc, exp);
        end
        drive_op(8'h42, 8'h12, 8'h34, 8'hA5);
        wait_done(cyc, obs);
        exp = exp_q.pop_front();
        tests_run++;
        if (obs !== exp || cyc != 1 || illegal !== 1'b1 || out !== '0 || out_hi !== '0 || flags_out !== 8'hA5) begin
            fails++;
            $display("FAIL b2b_illegal: got %h ill=%b out=%h fl=%h, expected %h ill=1 out=0 fl=a5",
                     obs, illegal, out, flags_out, exp);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL pulse_width: got done=%b ill=%b one cycle later, expected 0 0", done, illegal);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] obs, exp;
        int cyc, lat;
        logic [7:0] op;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0 || i == 0) @(negedge clk);
            op = 8'($urandom_range(0, 11));
            drive_op(op, W'($urandom), W'($urandom), 8'($urandom));
            wait_done(cyc, obs);
            lat = (op == 8'h09) ? W + 1 : 1;
            exp = exp_q.pop_front();
            tests_run++;
            if (obs !== exp || cyc != lat) begin
                fails++;
                $display("FAIL random_%0d op=%h: got %h after %0d cycles, expected %h after %0d",
                         i, op, obs, cyc, exp, lat);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [EW-1:0] obs, exp;
        int cyc, seen;
        @(negedge clk);
        drive_op(8'h01, 8'h33, 8'h44, 8'h00);
        wait_done(cyc, obs);
        void'(exp_q.pop_front());
        @(negedge clk);
        drive_op(8'h09, 8'hC3, 8'h5A, 8'h40);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, illegal, out, out_hi, flags_out} !== '0) begin
            fails++;
            $display("FAIL mid_mul_reset: got busy=%b done=%b out=%h hi=%h fl=%h, expected all 0",
                     busy, done, out, out_hi, flags_out);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_mul_no_done: got %0d cycles with done/busy, expected 0", seen);
        end
        drive_op(8'h01, 8'h01, 8'h01, 8'h00);
        wait_done(cyc, obs);
        exp = exp_q.pop_front();
        tests_run++;
        if (obs !== exp || cyc != 1 || out !== 8'h02) begin
            fails++;
            $display("FAIL post_reset_add: got %h out=%h after %0d cycles, expected %h out=02 after 1",
                     obs, out, cyc, exp);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the combinational CPU ALU.
- Accepts one operation per start/done handshake and computes full status flags (C, Z, N, V, S, H) in the AVR SREG layout.
- Adds carry-chained ops (ADC/SBC) and a multi-cycle unsigned multiply (shift-add, 2*DATA_WIDTH result).
- Sits between the control unit and the register file; the control unit writes results and flags back only on done.

Parameters:
- DATA_WIDTH, 8: operand and result width; legal range 4..32.
- MUL_ENABLE, 1: 1 implements MUL; 0 makes MUL decode as illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- opsel  input  8  operation code; sampled with start.
- rd  input  DATA_WIDTH  first operand; sampled with start.
- rr  input  DATA_WIDTH  second operand; sampled with start.
- flags_in  input  8  SREG: bit0 C, 1 Z, 2 N, 3 V, 4 S, 5 H, 6 T, 7 I.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; out, out_hi and flags_out are valid in the same cycle.
- out  output  DATA_WIDTH  result; low half for MUL.
- out_hi  output  DATA_WIDTH  MUL high half; 0 for all other ops.
- flags_out  output  8  updated SREG.
- illegal  output  1  pulses with done when opsel is undecoded.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, illegal=0.
  - out=0, out_hi=0, flags_out=0.
  - Multiply accumulator and counter cleared.
- Opcodes:
  - 0x00 NONE: out=rr.
  - 0x01 ADD, 0x02 ADC, 0x03 SUB, 0x04 SBC.
  - 0x05 AND, 0x06 OR, 0x07 XOR.
  - 0x08 NEG: out=~rd, matching the existing ALU.
  - 0x09 MUL. All other codes are illegal.
- State machine IDLE -> EXEC -> IDLE:
  - IDLE with start=1: latch opsel, rd, rr and flags_in; busy=1 from the next cycle.
  - Single-cycle ops: result and done appear one cycle after start, so latency is 2 edges. start accepted at edge N gives done high after edge N+1.
  - MUL: state MUL runs DATA_WIDTH iterations, one per cycle (shift-add, LSB-first on rr). done is asserted after DATA_WIDTH+1 cycles.
  - done is high exactly one cycle; busy drops in the same cycle done rises, and state returns to IDLE.
  - start while busy=1 is ignored (no queueing). start in the done cycle is accepted, giving back-to-back throughput.
- Arithmetic (DATA_WIDTH bits, MSB = sign bit):
  - ADD/ADC: {C,out}=rd+rr+(ADC?C_in:0).
  - SUB/SBC: out=rd-rr-(SBC?C_in:0); C=1 on unsigned borrow.
  - H: carry/borrow out of bit 3, arithmetic ops only.
  - V: signed overflow. ADD: operands have the same sign and the result sign differs. SUB: operands have different signs and the result sign equals rr's sign.
  - N=out[MSB]; S=N^V.
  - Z: ADD/SUB/logic/NEG give Z=(out==0). ADC/SBC give Z=(out==0)&Z_in, for multi-precision chains.
  - Logic ops and NEG: V=0; C and H unchanged.
  - NONE: flags unchanged.
  - MUL: out_hi:out=rd*rr unsigned; C=product[2*DATA_WIDTH-1]; Z=(product==0); N, V, S, H unchanged.
  - T and I always pass through from the latched flags_in.
- Illegal opcode (or MUL with MUL_ENABLE=0):
  - Completes in single-cycle timing with illegal=1.
  - out=0 and out_hi=0; flags_out = latched flags_in, unchanged.
- Outputs hold their last values between operations. Downstream must consume them only on done.
- Reset asserted mid-MUL aborts the operation immediately; no done is produced; the block returns to IDLE with reset values.
- Operand and flag changes while busy have no effect on the in-flight operation.

Test Plan:
- Reset, then ADD rd=100, rr=50, flags_in=0 -> done 2 edges after start; out=150; C=0, V=1, N=1, S=0, Z=0, H=0.
- SUB rd=0x10, rr=0x10 -> out=0, Z=1, C=0. Then SBC rd=0, rr=0, flags_in C=1, Z=1 -> out=0xFF, C=1, Z=0, N=1.
- ADC chain: ADD rd=0xFF, rr=0x01 gives out=0, C=1, Z=1, H=1. Feed those flags into ADC rd=0, rr=0 -> out=1, Z=0, C=0.
- MUL rd=0xFF, rr=0xFF (DATA_WIDTH=8) -> busy for 8 cycles; done 9 cycles after start; out_hi:out=0xFE01, C=1. A start pulsed mid-operation is ignored.
- Back-to-back: start AND (0xF0 & 0x3C) in the done cycle of a prior op -> accepted; out=0x30. Then opsel=0x42 -> illegal=1, out=0, flags_out=flags_in.
- Drop rst_n at MUL iteration 4 -> outputs go to 0 immediately and no done occurs. After release, ADD 1+1 gives out=2.
